uart_miner_ctrl: RTL and testbench

- Command/response sequencer between the UART byte interfaces (uart_rx / uart_tx inside uart_wrapper) and the hashing core.
- Receives a framed block header over UART, loads it into the miner, and starts it.
- Waits for the miner result and streams a result frame back over UART.
- Holds the last found nonce for the seven-segment display path.

---
 rtl/uart_miner_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_miner_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_miner_ctrl.sv
// uart_miner_ctrl: command/response sequencer between the UART byte streams
// and the hashing core. Collects a SYNC-framed block header, starts the
// miner, then streams the result (found nonce, exhausted, or aborted) back.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   rx_valid, rx_data   received byte strobe and data
//   tx_valid, tx_ready  transmit handshake; transfer on tx_valid && tx_ready
//   tx_data             byte to transmit, stable while tx_valid is held
//   hdr_data            assembled header, first received byte in the MSBs
//   miner_start/abort   one-cycle control pulses to the miner
//   miner_found/done    one-cycle result pulses from the miner
//   miner_nonce         winning nonce, valid with miner_found
//   last_nonce          most recent winning nonce, for display
//   busy                high whenever not idle
module uart_miner_ctrl #(
  parameter int unsigned HDR_BYTES  = 76,
  parameter int unsigned RX_TIMEOUT = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55,
  parameter logic [7:0]  ABORT_BYTE = 8'h18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic [HDR_BYTES*8-1:0] hdr_data,
  output logic                   miner_start,
  output logic                   miner_abort,
  input  logic                   miner_found,
  input  logic                   miner_done,
  input  logic [31:0]            miner_nonce,
  output logic [31:0]            last_nonce,
  output logic                   busy
);

  localparam int unsigned HdrW = HDR_BYTES * 8;
  localparam int unsigned CntW = $clog2(HDR_BYTES + 1);
  localparam int unsigned TmrW = $clog2(RX_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(HDR_BYTES - 1);
  localparam logic [TmrW-1:0] TmrMax  = TmrW'(RX_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StMine, StTx} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [HdrW-1:0]   hdr_q, hdr_d;
  // Reply bytes go out from the top byte; shifted left after each transfer.
  logic [39:0]       reply_q, reply_d;
  logic [2:0]        left_q, left_d;
  logic              abort_q, abort_d;
  logic [31:0]       last_nonce_q, last_nonce_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      hdr_q        <= '0;
      reply_q      <= '0;
      left_q       <= '0;
      abort_q      <= 1'b0;
      last_nonce_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      hdr_q        <= hdr_d;
      reply_q      <= reply_d;
      left_q       <= left_d;
      abort_q      <= abort_d;
      last_nonce_q <= last_nonce_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    hdr_d        = hdr_q;
    reply_d      = reply_q;
    left_d       = left_q;
    abort_d      = 1'b0;
    last_nonce_d = last_nonce_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = StLoad;
          byte_cnt_d = '0;
          timer_d    = '0;
        end
      end
      StLoad: begin
        // SYNC_BYTE is plain data here: no resync inside a frame.
        if (rx_valid) begin
          hdr_d      = {hdr_q[HdrW-9:0], rx_data};
          byte_cnt_d = byte_cnt_q + 1'b1;
          timer_d    = '0;
          if (byte_cnt_q == LastIdx) state_d = StStart;
        end else begin
          if (timer_q != TmrMax) timer_d = timer_q + 1'b1;
          // Partial header stays in hdr_data but is never started.
          if (timer_d == TmrMax) state_d = StIdle;
        end
      end
      StStart: begin
        state_d = StMine;
      end
      StMine: begin
        // found > done > abort when coincident.
        if (miner_found) begin
          last_nonce_d = miner_nonce;
          reply_d      = {8'h01, miner_nonce};
          left_d       = 3'd5;
          state_d      = StTx;
        end else if (miner_done) begin
          reply_d = {8'h00, 32'h0};
          left_d  = 3'd1;
          state_d = StTx;
        end else if (rx_valid && rx_data == ABORT_BYTE) begin
          abort_d = 1'b1;
          reply_d = {ABORT_BYTE, 32'h0};
          left_d  = 3'd1;
          state_d = StTx;
        end
      end
      StTx: begin
        if (tx_ready) begin
          reply_d = {reply_q[31:0], 8'h00};
          left_d  = left_q - 1'b1;
          if (left_q == 3'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tx_valid    = (state_q == StTx);
  assign tx_data     = reply_q[39:32];
  assign hdr_data    = hdr_q;
  assign miner_start = (state_q == StStart);
  assign miner_abort = abort_q;
  assign last_nonce  = last_nonce_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_miner_ctrl.sv
// Self-checking bench for uart_miner_ctrl with a 4-byte header and a short
// inter-byte timeout. Expected reply bytes are queued when the miner event is
// driven and popped by a monitor as each byte is transferred.
module tb_uart_miner_ctrl;

  localparam int unsigned HB = 4;
  localparam int unsigned TO = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic [HB*8-1:0] hdr_data;
  logic          miner_start;
  logic          miner_abort;
  logic          miner_found;
  logic          miner_done;
  logic [31:0]   miner_nonce;
  logic [31:0]   last_nonce;
  logic          busy;

  uart_miner_ctrl #(
    .HDR_BYTES (HB),
    .RX_TIMEOUT(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .hdr_data   (hdr_data),
    .miner_start(miner_start),
    .miner_abort(miner_abort),
    .miner_found(miner_found),
    .miner_done (miner_done),
    .miner_nonce(miner_nonce),
    .last_nonce (last_nonce),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];
  int xfers     = 0;
  int starts    = 0;
  int aborts    = 0;
  bit throttle  = 1'b0;
  int cyc       = 0;
  bit hold_prev = 1'b0;
  logic [7:0] hold_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tx_ready driver: always ready, or ready one cycle in three.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      tx_ready = throttle ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (miner_start) starts++;
      if (miner_abort) aborts++;
      if (tx_valid && hold_prev) check("tx_hold", tx_data, hold_data);
      if (tx_valid && tx_ready) begin
        check("tx_expected_pending", sb.size() > 0, 1);
        if (sb.size() > 0) check("tx_byte", tx_data, sb.pop_front());
        xfers++;
      end
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends SYNC plus a 4-byte header; returns positioned in the START cycle.
  task automatic load_frame(input logic [31:0] hdr);
    send_byte(8'h55);
    for (int i = 3; i >= 0; i--) send_byte(hdr[i*8 +: 8]);
  endtask

  task automatic push_found(input logic [31:0] n);
    sb.push_back(8'h01);
    for (int i = 3; i >= 0; i--) sb.push_back(n[i*8 +: 8]);
  endtask

  task automatic pulse_found(input logic [31:0] n);
    miner_found = 1'b1;
    miner_nonce = n;
    tick();
    miner_found = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    check(tag, sb.size(), 0);
  endtask

  int base;
  int s0;
  int a0;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    miner_found = 1'b0; miner_done = 1'b0; miner_nonce = 32'h0;
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_hdr", hdr_data, 0);
    check("rst_start", miner_start, 0);
    check("rst_abort", miner_abort, 0);
    check("rst_last_nonce", last_nonce, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Non-sync byte in idle is ignored.
    send_byte(8'hA7);
    check("idle_ignore", busy, 0);

    // Header load and start latency.
    s0 = starts;
    load_frame(32'hDEADBEEF);
    check("start_latency", miner_start, 1);
    check("hdr_load", hdr_data, 32'hDEADBEEF);
    check("busy_start", busy, 1);
    tick();
    check("start_one_cycle", miner_start, 0);
    check("start_count", starts - s0, 1);

    // Found with tx_ready always high.
    base = xfers;
    push_found(32'h12345678);
    pulse_found(32'h12345678);
    check("found_tx_latency", tx_valid, 1);
    wait_drain("drain_found");
    check("xfers_found", xfers - base, 5);
    check("last_nonce", last_nonce, 32'h12345678);
    check("idle_after_tx", busy, 0);

    // Found with throttled tx_ready.
    load_frame(32'h01020304);
    tick();
    throttle = 1'b1;
    base = xfers;
    push_found(32'h9ABCDEF0);
    pulse_found(32'h9ABCDEF0);
    wait_drain("drain_throttle");
    check("xfers_throttle", xfers - base, 5);
    check("last_nonce_2", last_nonce, 32'h9ABCDEF0);
    check("idle_throttle", busy, 0);
    throttle = 1'b0;

    // Abort while mining; 0x55 in MINE is ignored.
    load_frame(32'hCAFEF00D);
    tick();
    send_byte(8'h55);
    check("mine_ignore", tx_valid, 0);
    a0 = aborts;
    sb.push_back(8'h18);
    send_byte(8'h18);
    check("abort_pulse", miner_abort, 1);
    tick();
    check("abort_one_cycle", miner_abort, 0);
    wait_drain("drain_abort");
    check("abort_count", aborts - a0, 1);

    // Done alone.
    load_frame(32'h0BADC0DE);
    tick();
    sb.push_back(8'h00);
    miner_done = 1'b1;
    tick();
    miner_done = 1'b0;
    wait_drain("drain_done");
    check("last_nonce_kept", last_nonce, 32'h9ABCDEF0);

    // Found, done and abort coincide: found wins, no abort pulse.
    load_frame(32'h11111111);
    tick();
    a0 = aborts;
    push_found(32'hA5A50F0F);
    miner_done = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h18;
    pulse_found(32'hA5A50F0F);
    miner_done = 1'b0;
    rx_valid = 1'b0;
    check("prio_no_abort", miner_abort, 0);
    wait_drain("drain_prio");
    check("prio_abort_count", aborts - a0, 0);
    check("prio_nonce", last_nonce, 32'hA5A50F0F);

    // Inter-byte timeout discards the partial frame.
    s0 = starts;
    send_byte(8'h55);
    send_byte(8'hAA);
    check("load_busy", busy, 1);
    repeat (TO - 2) tick();
    check("timeout_not_early", busy, 1);
    repeat (4) tick();
    check("timeout_idle", busy, 0);
    check("timeout_no_start", starts - s0, 0);
    load_frame(32'h11223344);
    check("reload_start", miner_start, 1);
    check("reload_hdr", hdr_data, 32'h11223344);
    tick();
    sb.push_back(8'h00);
    miner_done = 1'b1;
    tick();
    miner_done = 1'b0;
    wait_drain("drain_reload");

    // Reset mid-transfer after two of five bytes.
    load_frame(32'h55555555);
    tick();
    base = xfers;
    push_found(32'hFEEDFACE);
    pulse_found(32'hFEEDFACE);
    for (int i = 0; i < 50 && (xfers - base) < 2; i++) begin
      @(negedge clock);
      #1;
    end
    check("two_bytes_before_reset", xfers - base, 2);
    reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_last_nonce", last_nonce, 0);
    reset = 1'b0;
    tick();
    load_frame(32'h89ABCDEF);
    check("post_reset_hdr", hdr_data, 32'h89ABCDEF);
    tick();
    base = xfers;
    push_found(32'h00C0FFEE);
    pulse_found(32'h00C0FFEE);
    wait_drain("drain_post_reset");
    check("xfers_post_reset", xfers - base, 5);
    check("post_reset_nonce", last_nonce, 32'h00C0FFEE);
    check("post_reset_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
